seg_display_driver: RTL and testbench

- Consumes the 20-bit packed character word produced by the mode blocks: four 5-bit character codes, digit 3 = [19:15] (leftmost) down to digit 0 = [4:0].
- Time-multiplexes the four-digit common-anode 7-segment display and decodes each 5-bit code to a segment glyph.
- Buffers updates so that the display only changes at frame boundaries; this prevents tearing.
- Adds inter-digit anti-ghost blanking and per-digit blinking.

---
 rtl/seg_display_driver.sv | 126 ++++++++++++
 tb/tb_seg_display_driver.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_driver.sv
// rtl/seg_display_driver.sv - four-digit multiplexed 7-segment driver with frame-synchronous loads
module seg_display_driver #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 2_000,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] seg_data,
  input  logic        data_valid,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        update_pending
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  typedef enum logic {S_BLANK, S_DRIVE} slot_state_t;

  slot_state_t   state;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    digit;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;
  logic [19:0]   act_word, pend_word;
  logic [3:0]    act_dp, act_blink, pend_dp, pend_blink;
  logic [4:0]    cur_code;
  logic          last_slot, commit, suppress;

  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'h00: glyph = 7'h3F;  5'h01: glyph = 7'h06;  5'h02: glyph = 7'h5B;  5'h03: glyph = 7'h4F;
      5'h04: glyph = 7'h66;  5'h05: glyph = 7'h6D;  5'h06: glyph = 7'h7D;  5'h07: glyph = 7'h07;
      5'h08: glyph = 7'h7F;  5'h09: glyph = 7'h6F;  5'h0A: glyph = 7'h77;  5'h0B: glyph = 7'h7C;
      5'h0C: glyph = 7'h39;  5'h0D: glyph = 7'h5E;  5'h0E: glyph = 7'h79;  5'h0F: glyph = 7'h71;
      5'h10: glyph = 7'h76;  5'h11: glyph = 7'h1E;  5'h12: glyph = 7'h38;  5'h13: glyph = 7'h54;
      5'h14: glyph = 7'h5C;  5'h15: glyph = 7'h73;  5'h16: glyph = 7'h50;  5'h17: glyph = 7'h78;
      5'h18: glyph = 7'h3E;  5'h19: glyph = 7'h6E;  5'h1A: glyph = 7'h40;  5'h1B: glyph = 7'h08;
      5'h1C: glyph = 7'h3D;  5'h1D: glyph = 7'h1C;  5'h1E: glyph = 7'h63;  default: glyph = 7'h00;
    endcase
  endfunction

  always_comb begin
    cur_code = 5'h1F;
    case (digit)
      2'd3: cur_code = act_word[19:15];
      2'd2: cur_code = act_word[14:10];
      2'd1: cur_code = act_word[9:5];
      default: cur_code = act_word[4:0];
    endcase
  end

  assign last_slot = (slot_cnt == SW'(SCAN_DIV - 1));
  // The 0 -> 3 digit wrap is the frame boundary where buffered data becomes visible.
  assign commit    = last_slot && (digit == 2'd0);
  assign suppress  = blink_off && act_blink[digit];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an             <= 4'hF;
      seg            <= 7'h7F;
      dp             <= 1'b1;
      update_pending <= 1'b0;
      state          <= S_BLANK;
      slot_cnt       <= '0;
      digit          <= 2'd3;
      blink_cnt      <= '0;
      blink_off      <= 1'b0;
      act_word       <= '1;
      act_dp         <= '0;
      act_blink      <= '0;
      pend_word      <= '1;
      pend_dp        <= '0;
      pend_blink     <= '0;
    end else begin
      if (state == S_DRIVE) begin
        an  <= ~(4'b0001 << digit);
        seg <= suppress ? 7'h7F : ~glyph(cur_code);
        dp  <= ~(act_dp[digit] & ~suppress);
      end else begin
        an  <= 4'hF;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end

      if (last_slot) begin
        slot_cnt <= '0;
        state    <= S_BLANK;
        digit    <= digit - 2'd1;
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
        if (slot_cnt == SW'(BLANK_CYC - 1))
          state <= S_DRIVE;
      end

      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end

      // A load landing on the commit edge goes straight to the active set.
      if (commit) begin
        update_pending <= 1'b0;
        if (data_valid) begin
          act_word  <= seg_data;
          act_dp    <= dp_in;
          act_blink <= blink_en;
        end else if (update_pending) begin
          act_word  <= pend_word;
          act_dp    <= pend_dp;
          act_blink <= pend_blink;
        end
      end else if (data_valid) begin
        pend_word      <= seg_data;
        pend_dp        <= dp_in;
        pend_blink     <= blink_en;
        update_pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_display_driver.sv
// tb/tb_seg_display_driver.sv - randomized and directed bench for seg_display_driver against a position-based model
module tb_seg_display_driver;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BD = 64;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] seg_data;
  logic        data_valid;
  logic [3:0]  dp_in;
  logic [3:0]  blink_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        update_pending;

  int vectors = 0;
  int miscompares = 0;

  seg_display_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .seg_data(seg_data), .data_valid(data_valid),
    .dp_in(dp_in), .blink_en(blink_en), .an(an), .seg(seg), .dp(dp),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [32] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
    7'h76, 7'h1E, 7'h38, 7'h54, 7'h5C, 7'h73, 7'h50, 7'h78,
    7'h3E, 7'h6E, 7'h40, 7'h08, 7'h3D, 7'h1C, 7'h63, 7'h00};

  // Model: n = edges since reset release; display position before each edge is n.
  int          n;
  int          m_dig;
  logic        m_sup;
  logic [19:0] m_word, p_word;
  logic [3:0]  m_dp, p_dp, m_blink, p_blink;
  logic        m_pend;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n = 0; m_word = '1; m_dp = 0; m_blink = 0; m_pend = 0;
      p_word = '1; p_dp = 0; p_blink = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      m_dig = 3 - (n / SD) % 4;
      if (n % SD < BC) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        m_sup = ((n / BD) % 2 == 1) && m_blink[m_dig];
        e_an  = ~(4'b0001 << m_dig);
        e_seg = m_sup ? 7'h7F : ~glyph_tab[m_word[5*m_dig +: 5]];
        e_dp  = ~(m_dp[m_dig] & ~m_sup);
      end
      n = n + 1;
      if (n % FR == 0) begin
        if (data_valid) {m_word, m_dp, m_blink} = {seg_data, dp_in, blink_en};
        else if (m_pend) {m_word, m_dp, m_blink} = {p_word, p_dp, p_blink};
        m_pend = 1'b0;
      end else if (data_valid) begin
        {p_word, p_dp, p_blink} = {seg_data, dp_in, blink_en};
        m_pend = 1'b1;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; data_valid = 1'b0; seg_data = '1; dp_in = '0; blink_en = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({an, seg, dp, update_pending} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got an=%h seg=%h dp=%b pend=%b, want an=f seg=7f dp=1 pend=0", an, seg, dp, update_pending);
    end
    reset = 1'b1;
    for (int i = 1; i <= FR; i++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, update_pending} !== {e_an, e_seg, e_dp, m_pend}) begin
        miscompares++;
        $display("FAIL reset_model: got %h/%h/%b/%b want %h/%h/%b/%b", an, seg, dp, update_pending, e_an, e_seg, e_dp, m_pend);
      end
      if (i == 2) begin
        vectors++;
        if (an !== 4'hF) begin miscompares++; $display("FAIL first_blank: an=%h want f", an); end
      end
      if (i == 3) begin
        vectors++;
        if (an !== 4'h7) begin miscompares++; $display("FAIL first_drive: an=%h want 7", an); end
      end
      vectors++;
      if (seg !== 7'h7F || dp !== 1'b1) begin
        miscompares++;
        $display("FAIL idle_blank: seg=%h dp=%b want 7f/1", seg, dp);
      end
    end
  endtask

  task automatic test_load_mid_frame();
    logic [3:0] want_an [4] = '{4'h7, 4'hB, 4'hD, 4'hE};
    logic [6:0] want_g  [4] = '{7'h06, 7'h5B, 7'h4F, 7'h66};
    do @(negedge clk); while (n % FR != 10);
    data_valid = 1'b1; seg_data = {5'h01, 5'h02, 5'h03, 5'h04}; dp_in = '0; blink_en = '0;
    do begin
      @(negedge clk);
      data_valid = 1'b0;
      vectors++;
      if ({an, seg, dp, update_pending} !== {e_an, e_seg, e_dp, m_pend}) begin
        miscompares++;
        $display("FAIL load_model: got %h/%h/%b/%b want %h/%h/%b/%b", an, seg, dp, update_pending, e_an, e_seg, e_dp, m_pend);
      end
      vectors++;
      if (update_pending !== (n % FR != 0)) begin
        miscompares++;
        $display("FAIL load_pending: pend=%b want %b at pos %0d", update_pending, (n % FR != 0), n % FR);
      end
    end while (n % FR != 0);
    for (int k = 1; k <= FR; k++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, update_pending} !== {e_an, e_seg, e_dp, m_pend}) begin
        miscompares++;
        $display("FAIL load_frame_model: got %h/%h/%b/%b want %h/%h/%b/%b", an, seg, dp, update_pending, e_an, e_seg, e_dp, m_pend);
      end
      if (k % SD == 3) begin
        vectors++;
        if (an !== want_an[k / SD] || seg !== ~want_g[k / SD]) begin
          miscompares++;
          $display("FAIL load_glyph: an=%h seg=%h want %h/%h", an, seg, want_an[k / SD], ~want_g[k / SD]);
        end
      end
      if (k % SD == 1 || k % SD == 2) begin
        vectors++;
        if (an !== 4'hF) begin miscompares++; $display("FAIL load_gap: an=%h want f at k=%0d", an, k); end
      end
    end
  endtask

  task automatic test_last_wins();
    do @(negedge clk); while (n % FR != 4);
    data_valid = 1'b1; seg_data = {5'h10, 5'h11, 5'h12, 5'h13};
    @(negedge clk); data_valid = 1'b0;
    do @(negedge clk); while (n % FR != 12);
    data_valid = 1'b1; seg_data = {4{5'h1A}};
    @(negedge clk); data_valid = 1'b0;
    do @(negedge clk); while (n % FR != 0);
    for (int k = 1; k <= FR; k++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, update_pending} !== {e_an, e_seg, e_dp, m_pend}) begin
        miscompares++;
        $display("FAIL lastwins_model: got %h/%h/%b/%b want %h/%h/%b/%b", an, seg, dp, update_pending, e_an, e_seg, e_dp, m_pend);
      end
      if ((k - 1) % SD >= BC) begin
        vectors++;
        if (seg !== 7'h3F) begin miscompares++; $display("FAIL lastwins_dash: seg=%h want 3f at k=%0d", seg, k); end
      end
    end
  endtask

  task automatic test_commit_bypass();
    logic [6:0] want_g [4] = '{7'h77, 7'h7C, 7'h39, 7'h5E};
    do @(negedge clk); while (n % FR != FR - 1);
    data_valid = 1'b1; seg_data = {5'h0A, 5'h0B, 5'h0C, 5'h0D}; dp_in = '0; blink_en = '0;
    @(negedge clk); data_valid = 1'b0;
    for (int k = 1; k <= FR; k++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, update_pending} !== {e_an, e_seg, e_dp, m_pend}) begin
        miscompares++;
        $display("FAIL bypass_model: got %h/%h/%b/%b want %h/%h/%b/%b", an, seg, dp, update_pending, e_an, e_seg, e_dp, m_pend);
      end
      vectors++;
      if (update_pending !== 1'b0) begin miscompares++; $display("FAIL bypass_pending: pend=%b want 0", update_pending); end
      if (k % SD == 3) begin
        vectors++;
        if (seg !== ~want_g[k / SD]) begin
          miscompares++;
          $display("FAIL bypass_glyph: seg=%h want %h", seg, ~want_g[k / SD]);
        end
      end
    end
  endtask

  task automatic test_blink();
    bit seen_on = 0, seen_off = 0;
    do @(negedge clk); while (n % FR != FR - 1);
    data_valid = 1'b1; seg_data = {5'h1F, 5'h1F, 5'h08, 5'h08}; dp_in = 4'b0010; blink_en = 4'b0001;
    @(negedge clk); data_valid = 1'b0;
    for (int k = 1; k <= 4 * FR; k++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, update_pending} !== {e_an, e_seg, e_dp, m_pend}) begin
        miscompares++;
        $display("FAIL blink_model: got %h/%h/%b/%b want %h/%h/%b/%b", an, seg, dp, update_pending, e_an, e_seg, e_dp, m_pend);
      end
      if ((k - 1) % FR == 18) begin
        vectors++;
        if (seg !== 7'h00 || dp !== 1'b0) begin
          miscompares++;
          $display("FAIL blink_digit1: seg=%h dp=%b want 00/0", seg, dp);
        end
      end
      if ((k - 1) % FR == 4 || (k - 1) % FR == 12) begin
        vectors++;
        if (seg !== 7'h7F) begin miscompares++; $display("FAIL blink_blank_digits: seg=%h want 7f", seg); end
      end
      if ((k - 1) % FR == 28) begin
        if (seg === 7'h00) seen_on = 1;
        if (seg === 7'h7F) seen_off = 1;
      end
    end
    vectors++;
    if (!(seen_on && seen_off)) begin
      miscompares++;
      $display("FAIL blink_alternate: saw_on=%b saw_off=%b want 1/1", seen_on, seen_off);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, update_pending} !== {e_an, e_seg, e_dp, m_pend}) begin
        miscompares++;
        $display("FAIL random_model: got %h/%h/%b/%b want %h/%h/%b/%b", an, seg, dp, update_pending, e_an, e_seg, e_dp, m_pend);
      end
      data_valid = ($urandom_range(0, 5) == 0);
      seg_data   = 20'($urandom);
      dp_in      = 4'($urandom);
      blink_en   = 4'($urandom);
    end
    data_valid = 1'b0;
  endtask

  task automatic test_reset_async();
    do @(negedge clk); while (n % FR != 5);
    data_valid = 1'b1; seg_data = {5'h01, 5'h02, 5'h03, 5'h04};
    @(negedge clk); data_valid = 1'b0;
    do @(negedge clk); while (n % FR != 13);
    vectors++;
    if (update_pending !== 1'b1 || an !== 4'hB) begin
      miscompares++;
      $display("FAIL async_precond: pend=%b an=%h want 1/b", update_pending, an);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({an, seg, dp, update_pending} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got an=%h seg=%h dp=%b pend=%b want f/7f/1/0", an, seg, dp, update_pending);
    end
    @(negedge clk); reset = 1'b1;
    for (int k = 1; k <= 2 * FR; k++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, update_pending} !== {e_an, e_seg, e_dp, m_pend}) begin
        miscompares++;
        $display("FAIL async_model: got %h/%h/%b/%b want %h/%h/%b/%b", an, seg, dp, update_pending, e_an, e_seg, e_dp, m_pend);
      end
      vectors++;
      if (seg !== 7'h7F || update_pending !== 1'b0) begin
        miscompares++;
        $display("FAIL async_blank_after: seg=%h pend=%b want 7f/0", seg, update_pending);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_mid_frame();
    test_last_wins();
    test_commit_bypass();
    test_blink();
    test_random();
    test_reset_async();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
